// File: rtl/ring_monitor.sv
// Receive-side checker for one-hot ring counters: locks onto a rotating code,
// decodes the hot bit, counts laps, and flags/counts rotation faults.
module ring_monitor #(
  parameter  int WIDTH    = 4,
  parameter  int DIR      = 0,
  parameter  int LOCK_LEN = 2,
  localparam int IW       = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] ring_in,
  input  logic             clr,
  output logic [IW-1:0]    idx,
  output logic             locked,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [7:0]       err_count,
  output logic [7:0]       lap_count
);

  localparam int CW = $clog2(LOCK_LEN + 1);

  typedef enum logic {SEEK, LOCK} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [IW-1:0]    idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             seeded_q, seeded_d;
  logic             fault, lap_inc;
  logic             valid, match;
  logic [IW-1:0]    enc;
  logic [WIDTH-1:0] rot;

  assign valid  = $onehot(ring_in);
  assign match  = (ring_in == exp_q);
  assign locked = (state_q == LOCK);

  always_comb begin
    enc = '0;
    for (int i = 0; i < WIDTH; i++)
      if (ring_in[i]) enc = IW'(i);
  end

  generate
    if (DIR == 0) begin : g_up
      assign rot = {ring_in[WIDTH-2:0], ring_in[WIDTH-1]};
    end else begin : g_dn
      assign rot = {ring_in[0], ring_in[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    idx_d    = idx;
    cnt_d    = cnt_q;
    seeded_d = seeded_q;
    fault    = 1'b0;
    lap_inc  = 1'b0;
    if (en) begin
      case (state_q)
        SEEK: begin
          if (valid) begin
            if (seeded_q && match) begin
              cnt_d = CW'(cnt_q + 1'b1);
              idx_d = enc;
              exp_d = rot;
              if (cnt_d == CW'(LOCK_LEN)) state_d = LOCK;
            end else begin
              idx_d    = enc;
              exp_d    = rot;
              cnt_d    = '0;
              seeded_d = 1'b1;
            end
          end else begin
            cnt_d = '0;
          end
        end
        LOCK: begin
          if (match) begin
            idx_d = enc;
            exp_d = rot;
            if (DIR == 0) lap_inc = (idx == IW'(WIDTH-1)) && (enc == '0);
            else          lap_inc = (idx == '0) && (enc == IW'(WIDTH-1));
          end else begin
            // A valid faulting code reseeds at once; an invalid one forces a fresh seed later.
            fault    = 1'b1;
            state_d  = SEEK;
            cnt_d    = '0;
            seeded_d = valid;
            if (valid) begin
              idx_d = enc;
              exp_d = rot;
            end
          end
        end
        default: state_d = SEEK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= SEEK;
      exp_q      <= '0;
      idx        <= '0;
      cnt_q      <= '0;
      seeded_q   <= 1'b0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= '0;
      lap_count  <= '0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      idx       <= idx_d;
      cnt_q     <= cnt_d;
      seeded_q  <= seeded_d;
      err_pulse <= fault;
      if (lap_inc) lap_count <= lap_count + 8'd1;
      // A fault in the same cycle as clr wins: the count restarts at one.
      if (fault) begin
        err_sticky <= 1'b1;
        if (clr)                     err_count <= 8'd1;
        else if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end else if (clr) begin
        err_sticky <= 1'b0;
        err_count  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ring_monitor.sv
// Directed self-checking bench for ring_monitor (WIDTH=4, DIR=0, LOCK_LEN=2).
module tb_ring_monitor;

  logic       clk, rst, en, clr;
  logic [3:0] ring_in;
  logic [1:0] idx;
  logic       locked, err_pulse, err_sticky;
  logic [7:0] err_count, lap_count;

  int checks   = 0;
  int failures = 0;

  ring_monitor #(.WIDTH(4), .DIR(0), .LOCK_LEN(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .ring_in   (ring_in),
    .clr       (clr),
    .idx       (idx),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_sticky(err_sticky),
    .err_count (err_count),
    .lap_count (lap_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_out(input string tag, input int i, input int l, input int ep,
                         input int es, input int ec, input int lc);
    chk({tag, ".idx"},        32'(idx),        32'(i));
    chk({tag, ".locked"},     32'(locked),     32'(l));
    chk({tag, ".err_pulse"},  32'(err_pulse),  32'(ep));
    chk({tag, ".err_sticky"}, 32'(err_sticky), 32'(es));
    chk({tag, ".err_count"},  32'(err_count),  32'(ec));
    chk({tag, ".lap_count"},  32'(lap_count),  32'(lc));
  endtask

  // Drive on the falling edge, then sample 1 time unit after the rising edge.
  task automatic step(input logic [3:0] code, input logic e, input logic c);
    @(negedge clk);
    ring_in = code;
    en      = e;
    clr     = c;
    @(posedge clk);
    #1;
  endtask

  // From SEEK: seed, two matches to lock, then an invalid code to fault.
  task automatic fault_seq(input logic c);
    step(4'b0001, 1'b1, 1'b0);
    step(4'b0010, 1'b1, 1'b0);
    step(4'b0100, 1'b1, 1'b0);
    step(4'b0000, 1'b1, c);
  endtask

  logic [3:0] garbage [3];

  initial begin
    garbage[0] = 4'b0110;
    garbage[1] = 4'b0000;
    garbage[2] = 4'b1111;
    rst = 1'b0; en = 1'b0; clr = 1'b0; ring_in = 4'b0000;

    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    step(4'b0001, 1'b1, 1'b0); chk_out("seed", 0, 0, 0, 0, 0, 0);
    step(4'b0010, 1'b1, 1'b0); chk_out("match1", 1, 0, 0, 0, 0, 0);
    step(4'b0100, 1'b1, 1'b0); chk_out("lock", 2, 1, 0, 0, 0, 0);

    step(4'b1000, 1'b1, 1'b0); chk_out("lap_pre", 3, 1, 0, 0, 0, 0);
    step(4'b0001, 1'b1, 1'b0); chk_out("lap_wrap", 0, 1, 0, 0, 0, 1);

    step(4'b0100, 1'b1, 1'b0); chk_out("fault", 2, 0, 1, 1, 1, 1);
    step(4'b1000, 1'b1, 1'b0); chk_out("reseed", 3, 0, 0, 1, 1, 1);
    step(4'b0001, 1'b1, 1'b0); chk_out("relock", 0, 1, 0, 1, 1, 1);

    step(4'b0000, 1'b1, 1'b0); chk_out("inv_fault", 0, 0, 1, 1, 2, 1);
    step(4'b0000, 1'b1, 1'b0); chk_out("inv_seek", 0, 0, 0, 1, 2, 1);
    step(4'b0011, 1'b1, 1'b0); chk_out("inv_two", 0, 0, 0, 1, 2, 1);

    step(4'b0010, 1'b1, 1'b0); chk_out("seed2", 1, 0, 0, 1, 2, 1);
    step(4'b0100, 1'b1, 1'b0);
    step(4'b1000, 1'b1, 1'b0); chk_out("relock2", 3, 1, 0, 1, 2, 1);

    for (int k = 0; k < 3; k++) begin
      step(garbage[k], 1'b0, 1'b0);
      chk_out("en_hold", 3, 1, 0, 1, 2, 1);
    end
    step(4'b0001, 1'b1, 1'b0); chk_out("lap2", 0, 1, 0, 1, 2, 2);

    step(4'b0000, 1'b1, 1'b0); chk_out("fault3", 0, 0, 1, 1, 3, 2);
    fault_seq(1'b0);
    fault_seq(1'b0);           chk_out("count5", 2, 0, 1, 1, 5, 2);
    fault_seq(1'b1);           chk_out("clr_collide", 2, 0, 1, 1, 1, 2);
    step(4'b0000, 1'b1, 1'b1); chk_out("clr_only", 2, 0, 0, 0, 0, 2);

    repeat (260) fault_seq(1'b0);
    chk_out("saturate", 2, 0, 1, 1, 255, 2);

    #2 rst = 1'b0;
    #1 chk_out("async_rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    step(4'b0010, 1'b1, 1'b0); chk_out("post_rst", 1, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
